hybrid_chooser: RTL
===================

// Module: hybrid_chooser
// PURPOSE
//  Tournament selector directly downstream of the global and local predictors.
//  Per branch it picks one of Global_taken / Local_taken using a PC-indexed table
//  of 2-bit chooser counters, and drives the final Taken to fetch.
//  In-flight predictions wait in an in-order queue until resolution.
//  On resolution the queued entry trains the chooser and raises Mispredict.
// PARAMETERS
//  CHOOSER_BITS  10  chooser index width; table holds 2**CHOOSER_BITS counters
//  QUEUE_DEPTH    4  max unresolved predictions in flight (power of 2)
// PORTS
//  CLK              in   1   clock; all state updates on posedge
//  RESET            in   1   asynchronous, active-low reset
//  FLUSH            in   1   synchronous pipeline flush
//  Pred_valid       in   1   a conditional branch is being predicted this cycle
//  Instr_addr_input in   32  PC of that branch
//  Global_taken     in   1   global predictor's prediction for this PC
//  Local_taken      in   1   local predictor's prediction for this PC
//  Resolve_valid    in   1   oldest in-flight branch resolves this cycle
//  Branch_resolved  in   1   actual outcome (1 = taken); valid with Resolve_valid
//  Taken            out  1   final prediction (registered)
//  Taken_valid      out  1   Taken corresponds to an accepted Pred_valid
//  Mispredict       out  1   one-cycle pulse: resolved outcome != queued final prediction
//  Queue_full       out  1   combinational: count == QUEUE_DEPTH
// BEHAVIOUR
//  - Reset (async, RESET=0): Taken=0, Taken_valid=0, Mispredict=0, queue empty,
//    all chooser counters = 2'b01 (weakly prefer local).
//  - Index = Instr_addr_input[CHOOSER_BITS+1:2]. Counter MSB=1 selects global, 0 selects local.
//  - Predict: accept = Pred_valid && !Queue_full.
//    - Latency is 1 cycle: Taken <= chosen prediction, Taken_valid <= 1.
//    - Push {idx, Global_taken, Local_taken, final} at the queue tail.
//    - If Pred_valid && Queue_full: the request is dropped; Taken_valid <= 0 and Taken holds.
//    - Otherwise Taken_valid <= 0 and Taken holds.
//  - Resolve: pop = Resolve_valid && count != 0.
//    - Resolve_valid with the queue empty is ignored; no update, Mispredict stays 0.
//    - Mispredict <= (head.final != Branch_resolved); 0 in any cycle without a pop.
//  - Training happens only if head.g != head.l:
//    - g == outcome: counter +1, saturating at 2'b11.
//    - otherwise: counter -1, saturating at 2'b00.
//    - If head.g == head.l, the counter is unchanged.
//  - Push and pop in the same cycle: both performed and count unchanged.
//    Queue_full is computed before the pop, so a push is still refused when full.
//  - Lookup and training of the same index in one cycle: lookup sees the pre-update value.
//  - Pointers wrap modulo QUEUE_DEPTH; count is held in a $clog2(QUEUE_DEPTH)+1 bit register.
//  - FLUSH (synchronous, priority over predict and resolve):
//    - Queue emptied; Taken, Taken_valid and Mispredict cleared.
//    - Chooser counters retained.
//    - Pred_valid and Resolve_valid in the FLUSH cycle are ignored.
//  - RESET asserted mid-operation: immediate return to the reset state; no partial training.
// STRUCTURE
//  - config.v holds:
//    - CHOOSER_BITS and QUEUE_DEPTH defaults.
//    - Counter encodings: SNT=2'b00, WNT=2'b01, WT=2'b10, ST=2'b11.
//    - Queue entry width macro (CHOOSER_BITS+3).
//  - One sub-module: branch_pred_fifo.
//    - Parameterised width/depth.
//    - push/pop/full/empty/head.
//    - Same async active-low RESET and sync FLUSH.
//  - Chooser table and training logic live in hybrid_chooser.
// TESTING
//  - Reset: RESET=0 mid-stream -> Taken=0, Taken_valid=0, Queue_full=0; then with PC=0x40,
//    G=1, L=0 -> Taken=0 next cycle (local chosen).
//  - Training: PC=0x40, G=1, L=0, resolve taken, repeated twice -> counter 01->10->11;
//    third predict -> Taken=1, and a not-taken resolve then gives Mispredict=1.
//  - Agreement: G=L=1, resolve not-taken -> Mispredict=1, counter unchanged (01).
//  - Full: 4 accepted predicts with no resolve -> Queue_full=1; 5th Pred_valid -> Taken_valid=0.
//    Same cycle pop+push while full -> push refused, count=3.
//  - Order: predict PCs 0x40, 0x80 with outcomes T, N; resolve in order ->
//    each counter trains against its own entry.
//  - Empty resolve and flush:
//    - Resolve_valid with empty queue -> Mispredict=0, no counter change.
//    - FLUSH with 3 entries -> count=0, counters kept.

Source files
------------

// File: rtl/hybrid_chooser_pkg.sv
// Shared definitions for the tournament chooser: default sizes, the 2-bit
// chooser counter encoding and helpers for the queue entry layout and training.
package hybrid_chooser_pkg;

  // Default number of index bits into the chooser table (table = 2**bits counters)
  localparam int CHOOSER_BITS_DEFAULT = 10;

  // Default number of unresolved predictions that may be in flight (power of 2)
  localparam int QUEUE_DEPTH_DEFAULT  = 4;

  // Chooser counter states: the MSB set means "trust the global predictor"
  typedef enum logic [1:0] {
    CTR_SNT = 2'b00,
    CTR_WNT = 2'b01,
    CTR_WT  = 2'b10,
    CTR_ST  = 2'b11
  } ctr_e;

  // Queue entry layout, LSB first: final, local, global, then the chooser index
  localparam int ENTRY_FINAL_BIT  = 0;
  localparam int ENTRY_LOCAL_BIT  = 1;
  localparam int ENTRY_GLOBAL_BIT = 2;
  localparam int ENTRY_IDX_LSB    = 3;

  // Width of one in-flight queue entry for a given chooser index width
  function automatic int entryWidth(input int chooserBits);
    return chooserBits + 3;
  endfunction

  // Saturating step of a chooser counter; up=1 moves toward global, up=0 toward local
  function automatic ctr_e trainCtr(input ctr_e cur, input logic up);
    ctr_e res;
    res = cur;
    if (up) begin
      case (cur)
        CTR_SNT: res = CTR_WNT;
        CTR_WNT: res = CTR_WT;
        CTR_WT:  res = CTR_ST;
        CTR_ST:  res = CTR_ST;
        default: res = cur;
      endcase
    end else begin
      case (cur)
        CTR_SNT: res = CTR_SNT;
        CTR_WNT: res = CTR_SNT;
        CTR_WT:  res = CTR_WNT;
        CTR_ST:  res = CTR_WT;
        default: res = cur;
      endcase
    end
    return res;
  endfunction

endpackage

// File: rtl/hybrid_chooser_branch_pred_fifo.sv
// In-order queue holding predictions that are waiting for their branch to
// resolve. Push and pop are guarded against full/empty internally, so a
// refused push or an empty pop leaves the queue untouched.
module branch_pred_fifo #(
  parameter int WIDTH = 13,
  parameter int DEPTH = 4
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic             FLUSH,
  input  logic             push_i,
  input  logic [WIDTH-1:0] pushData_i,
  input  logic             pop_i,
  output logic             full_o,
  output logic             empty_o,
  output logic [WIDTH-1:0] head_o
);

  // DEPTH must be a power of two of at least 2 so the pointers wrap naturally
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wrPtr_q, wrPtr_d;
  logic [PTR_W-1:0] rdPtr_q, rdPtr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             doPush;
  logic             doPop;

  assign full_o  = (count_q == DEPTH_C);
  assign empty_o = (count_q == '0);
  assign head_o  = mem_q[rdPtr_q];

  assign doPush = push_i && !full_o && !FLUSH;
  assign doPop  = pop_i && !empty_o && !FLUSH;

  // Next pointer/count values; a flush empties the queue outright
  always_comb begin
    wrPtr_d = wrPtr_q;
    rdPtr_d = rdPtr_q;
    count_d = count_q;
    if (FLUSH) begin
      wrPtr_d = '0;
      rdPtr_d = '0;
      count_d = '0;
    end else begin
      if (doPush) begin
        wrPtr_d = wrPtr_q + 1'b1;
      end
      if (doPop) begin
        rdPtr_d = rdPtr_q + 1'b1;
      end
      case ({doPush, doPop})
        2'b10:   count_d = count_q + 1'b1;
        2'b01:   count_d = count_q - 1'b1;
        default: count_d = count_q;
      endcase
    end
  end

  // Pointer and occupancy registers, cleared asynchronously by reset
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      wrPtr_q <= '0;
      rdPtr_q <= '0;
      count_q <= '0;
    end else begin
      wrPtr_q <= wrPtr_d;
      rdPtr_q <= rdPtr_d;
      count_q <= count_d;
    end
  end

  // Entry storage; contents are only meaningful while counted as occupied
  always_ff @(posedge CLK) begin
    if (doPush) begin
      mem_q[wrPtr_q] <= pushData_i;
    end
  end

endmodule

// File: rtl/hybrid_chooser.sv
// Tournament chooser between the global and local predictors. A PC-indexed
// table of 2-bit counters picks which predictor drives Taken; each accepted
// prediction is queued until its branch resolves, at which point the queued
// entry trains its own counter and reports whether the final choice was wrong.
module hybrid_chooser
  import hybrid_chooser_pkg::*;
#(
  parameter int CHOOSER_BITS = CHOOSER_BITS_DEFAULT,
  parameter int QUEUE_DEPTH  = QUEUE_DEPTH_DEFAULT
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic        FLUSH,
  input  logic        Pred_valid,
  input  logic [31:0] Instr_addr_input,
  input  logic        Global_taken,
  input  logic        Local_taken,
  input  logic        Resolve_valid,
  input  logic        Branch_resolved,
  output logic        Taken,
  output logic        Taken_valid,
  output logic        Mispredict,
  output logic        Queue_full
);

  localparam int TABLE_SIZE = 1 << CHOOSER_BITS;
  localparam int ENTRY_W    = entryWidth(CHOOSER_BITS);

  ctr_e                    ctr_q [TABLE_SIZE];
  logic [CHOOSER_BITS-1:0] lookupIdx;
  logic                    chosen;
  logic                    accept;
  logic                    pop;
  logic                    fifoFull;
  logic                    fifoEmpty;
  logic [ENTRY_W-1:0]      pushEntry;
  logic [ENTRY_W-1:0]      headEntry;
  logic [CHOOSER_BITS-1:0] headIdx;
  logic                    headGlobal;
  logic                    headLocal;
  logic                    headFinal;
  logic                    trainEn;
  ctr_e                    trainedCtr;
  logic                    taken_q, taken_d;
  logic                    takenValid_q, takenValid_d;
  logic                    mispredict_q, mispredict_d;
  logic                    unusedAddrBits;

  // Word-aligned PC bits select the counter; the remaining PC bits carry no index information
  assign lookupIdx      = Instr_addr_input[CHOOSER_BITS+1:2];
  assign unusedAddrBits = ^{Instr_addr_input[31:CHOOSER_BITS+2], Instr_addr_input[1:0]};

  // Lookup reads the registered table, so a same-cycle training write is not visible yet
  assign chosen = ctr_q[lookupIdx][1] ? Global_taken : Local_taken;

  // Queue_full reflects occupancy before any pop this cycle, so a full queue refuses a push
  // even when the oldest entry resolves at the same time
  assign Queue_full = fifoFull;
  assign accept     = Pred_valid && !fifoFull && !FLUSH;
  assign pop        = Resolve_valid && !fifoEmpty && !FLUSH;

  assign pushEntry = {lookupIdx, Global_taken, Local_taken, chosen};

  assign headIdx    = headEntry[ENTRY_W-1:ENTRY_IDX_LSB];
  assign headGlobal = headEntry[ENTRY_GLOBAL_BIT];
  assign headLocal  = headEntry[ENTRY_LOCAL_BIT];
  assign headFinal  = headEntry[ENTRY_FINAL_BIT];

  // When both predictors agreed there is nothing to learn about which one to trust
  assign trainEn    = pop && (headGlobal != headLocal);
  assign trainedCtr = trainCtr(ctr_q[headIdx], headGlobal == Branch_resolved);

  branch_pred_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (QUEUE_DEPTH)
  ) u_fifo (
    .CLK        (CLK),
    .RESET      (RESET),
    .FLUSH      (FLUSH),
    .push_i     (accept),
    .pushData_i (pushEntry),
    .pop_i      (pop),
    .full_o     (fifoFull),
    .empty_o    (fifoEmpty),
    .head_o     (headEntry)
  );

  // Next values of the registered outputs; Taken holds between accepted predictions
  always_comb begin
    taken_d      = taken_q;
    takenValid_d = 1'b0;
    mispredict_d = 1'b0;
    if (FLUSH) begin
      taken_d = 1'b0;
    end else begin
      if (accept) begin
        taken_d      = chosen;
        takenValid_d = 1'b1;
      end
      if (pop) begin
        mispredict_d = headFinal ^ Branch_resolved;
      end
    end
  end

  // Registered outputs toward fetch
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      taken_q      <= 1'b0;
      takenValid_q <= 1'b0;
      mispredict_q <= 1'b0;
    end else begin
      taken_q      <= taken_d;
      takenValid_q <= takenValid_d;
      mispredict_q <= mispredict_d;
    end
  end

  // Chooser table: all counters start weakly preferring local; a flush keeps what was learned
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      for (int i = 0; i < TABLE_SIZE; i++) begin
        ctr_q[i] <= CTR_WNT;
      end
    end else if (trainEn) begin
      ctr_q[headIdx] <= trainedCtr;
    end
  end

  assign Taken       = taken_q;
  assign Taken_valid = takenValid_q;
  assign Mispredict  = mispredict_q;

endmodule
